// File: rtl/pipe_mem_access.sv
// MEM pipeline stage: drives a req/ack data-memory transaction, stalls upstream while it waits, registers MEM/WB.
// Optional macro MEM_ACCESS_CNT_EN adds free-running access and stall counters.
module pipe_mem_access #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit ALIGN_CHECK    = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        validM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  WA3M,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic        ByteM,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   output logic        StallM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [3:0]  WA3W,
   output logic        validW,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic        ErrorW
`ifdef MEM_ACCESS_CNT_EN
   ,
   output logic [31:0] mem_access_cnt,
   output logic [31:0] mem_stall_cnt
`endif
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0]  state;
   logic [7:0]  toCnt;

   logic [31:0] addr_p1;
   logic [3:0]  wa3_p1;
   logic        isStore_p1;
   logic        isByte_p1;
   logic        regWrite_p1;
   logic        memtoReg_p1;

   logic        memop;
   logic        misaligned;
   logic        misOp;
   logic        startAcc;
   logic        ackHit;
   logic        timeoutHit;

   logic [31:0] nReadData;
   logic [31:0] nAluOut;
   logic [3:0]  nWa3;
   logic        nValid;
   logic        nRegWrite;
   logic        nMemtoReg;
   logic        nError;

   function automatic logic [3:0] laneBe(input logic [1:0] off, input logic isByte);
      return isByte ? (4'b0001 << off) : 4'b1111;
   endfunction

   function automatic logic [31:0] laneWdata(input logic [31:0] wd, input logic isByte);
      return isByte ? {4{wd[7:0]}} : wd;
   endfunction

   function automatic logic [31:0] loadData(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic isByte, input logic isStore);
      if (isStore)
         return 32'h0;
      else if (isByte)
         return {24'h0, rdata[{off, 3'b000} +: 8]};
      else
         return rdata;
   endfunction

   assign memop      = validM & (MemReadM | MemWriteM);
   assign misaligned = ALIGN_CHECK && !ByteM && (ALUResultM[1:0] != 2'b00);
   assign misOp      = memop & misaligned;
   assign startAcc   = (state == IDLE) & memop & ~misaligned;
   assign ackHit     = (state == ACCESS) & dmem_ack;
   // An ack arriving in the last allowed cycle still completes the access.
   assign timeoutHit = (state == ACCESS) & ~dmem_ack & (toCnt == 8'(TIMEOUT_CYCLES - 1));
   assign StallM     = startAcc | ((state == ACCESS) & ~ackHit & ~timeoutHit);

   // Next MEM/WB contents; the default is a bubble.
   always_comb begin
      nReadData = 32'h0;
      nAluOut   = 32'h0;
      nWa3      = 4'h0;
      nValid    = 1'b0;
      nRegWrite = 1'b0;
      nMemtoReg = 1'b0;
      nError    = 1'b0;
      if (state == IDLE) begin
         if (!startAcc) begin
            nValid    = validM;
            nRegWrite = RegWriteM & ~misOp;
            nMemtoReg = MemtoRegM;
            nError    = misOp;
            nAluOut   = ALUResultM;
            nWa3      = WA3M;
         end
      end else if (ackHit || timeoutHit) begin
         nValid    = 1'b1;
         nRegWrite = regWrite_p1 & ackHit;
         nMemtoReg = memtoReg_p1;
         nError    = timeoutHit;
         nAluOut   = addr_p1;
         nWa3      = wa3_p1;
         nReadData = ackHit ? loadData(dmem_rdata, addr_p1[1:0], isByte_p1, isStore_p1) : 32'h0;
      end
   end

   // Stage boundary: MEM -> bus request registers and MEM/WB register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         toCnt       <= 8'h0;
         addr_p1     <= 32'h0;
         wa3_p1      <= 4'h0;
         isStore_p1  <= 1'b0;
         isByte_p1   <= 1'b0;
         regWrite_p1 <= 1'b0;
         memtoReg_p1 <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= 32'h0;
         dmem_wdata  <= 32'h0;
         dmem_be     <= 4'h0;
         ReadDataW   <= 32'h0;
         ALUOutW     <= 32'h0;
         WA3W        <= 4'h0;
         validW      <= 1'b0;
         RegWriteW   <= 1'b0;
         MemtoRegW   <= 1'b0;
         ErrorW      <= 1'b0;
      end else begin
         ReadDataW <= nReadData;
         ALUOutW   <= nAluOut;
         WA3W      <= nWa3;
         validW    <= nValid;
         RegWriteW <= nRegWrite;
         MemtoRegW <= nMemtoReg;
         ErrorW    <= nError;
         case (state)
            IDLE: begin
               if (startAcc) begin
                  state       <= ACCESS;
                  toCnt       <= 8'h0;
                  addr_p1     <= ALUResultM;
                  wa3_p1      <= WA3M;
                  isStore_p1  <= MemWriteM;
                  isByte_p1   <= ByteM;
                  regWrite_p1 <= RegWriteM;
                  memtoReg_p1 <= MemtoRegM;
                  dmem_req    <= 1'b1;
                  dmem_we     <= MemWriteM;
                  dmem_addr   <= {ALUResultM[31:2], 2'b00};
                  dmem_wdata  <= laneWdata(WriteDataM, ByteM);
                  dmem_be     <= laneBe(ALUResultM[1:0], ByteM);
               end
            end
            ACCESS: begin
               if (ackHit || timeoutHit) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end else begin
                  toCnt <= toCnt + 8'h1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ACCESS_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_access_cnt <= 32'h0;
         mem_stall_cnt  <= 32'h0;
      end else begin
         if (ackHit)
            mem_access_cnt <= mem_access_cnt + 32'h1;
         if (StallM)
            mem_stall_cnt <= mem_stall_cnt + 32'h1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_mem_access.sv
// Bench for pipe_mem_access: directed table, reset/late-ack sequences, then random ops against a transaction model.
module tb_pipe_mem_access;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        validM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [3:0]  WA3M;
   logic        MemReadM, MemWriteM, ByteM, RegWriteM, MemtoRegM;
   logic        StallM, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] ReadDataW, ALUOutW;
   logic [3:0]  WA3W;
   logic        validW, RegWriteW, MemtoRegW, ErrorW;
`ifdef MEM_ACCESS_CNT_EN
   logic [31:0] accCnt, stlCnt;
`endif

   int tests = 0;
   int fails = 0;
   int expAcc = 0;
   int expStl = 0;

   typedef struct {
      logic        v;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  wa3;
      logic        rd, wr, bt, rw, m2r;
      int          ackDly;
      logic [31:0] rdata;
      logic        bus;
      logic [31:0] eAddr;
      logic [3:0]  eBe;
      logic [31:0] eWd;
      logic        eWe;
      logic [31:0] eRd;
      logic        eErr, eRw, eVal;
   } vec_t;

   vec_t tbl[8];

   pipe_mem_access #(.TIMEOUT_CYCLES(TO), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .validM(validM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .WA3M(WA3M), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .ByteM(ByteM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .StallM(StallM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ReadDataW(ReadDataW),
      .ALUOutW(ALUOutW), .WA3W(WA3W), .validW(validW), .RegWriteW(RegWriteW),
      .MemtoRegW(MemtoRegW), .ErrorW(ErrorW)
`ifdef MEM_ACCESS_CNT_EN
      , .mem_access_cnt(accCnt), .mem_stall_cnt(stlCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic driveIdle();
      validM = 0; ALUResultM = 0; WriteDataM = 0; WA3M = 0;
      MemReadM = 0; MemWriteM = 0; ByteM = 0; RegWriteM = 0; MemtoRegM = 0;
      dmem_ack = 0; dmem_rdata = 0;
   endtask

   task automatic drive(input vec_t t);
      validM = t.v; ALUResultM = t.addr; WriteDataM = t.wd; WA3M = t.wa3;
      MemReadM = t.rd; MemWriteM = t.wr; ByteM = t.bt; RegWriteM = t.rw; MemtoRegM = t.m2r;
      dmem_ack = 0;
   endtask

   // Transaction-level model: what the bus and writeback should see for one instruction.
   function automatic vec_t mkExp(input vec_t t);
      vec_t r = t;
      int   off = int'(t.addr % 4);
      logic isMem = t.v && (t.rd || t.wr);
      logic mis = isMem && !t.bt && (off != 0);
      logic late = (t.ackDly > TO - 1);
      r.bus   = isMem && !mis;
      r.eAddr = t.addr - 32'(off);
      r.eBe   = t.bt ? 4'(1 << off) : 4'hF;
      r.eWd   = t.bt ? (t.wd & 32'hFF) * 32'h0101_0101 : t.wd;
      r.eWe   = t.wr;
      r.eVal  = isMem ? 1'b1 : t.v;
      r.eErr  = mis || (r.bus && late);
      r.eRw   = r.eErr ? 1'b0 : t.rw;
      if (r.bus && !late && !t.wr)
         r.eRd = t.bt ? (t.rdata >> (8 * off)) & 32'hFF : t.rdata;
      else
         r.eRd = 0;
      return r;
   endfunction

   task automatic checkW(input vec_t t, input string tag);
      chk({tag, ".validW"}, 32'(validW), 32'(t.eVal));
      chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(t.eRw));
      chk({tag, ".ErrorW"}, 32'(ErrorW), 32'(t.eErr));
      chk({tag, ".ReadDataW"}, ReadDataW, t.eRd);
      if (!t.eErr) begin
         chk({tag, ".ALUOutW"}, ALUOutW, t.addr);
         chk({tag, ".WA3W"}, 32'(WA3W), 32'(t.wa3));
         chk({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(t.m2r));
      end
   endtask

   task automatic runOp(input vec_t t, input string tag);
      drive(t);
      #1;
      if (!t.bus) begin
         chk({tag, ".stall"}, 32'(StallM), 0);
         chk({tag, ".noreq"}, 32'(dmem_req), 0);
         tick();
         checkW(t, tag);
      end else begin
         chk({tag, ".stall0"}, 32'(StallM), 1);
         expStl++;
         tick();
         chk({tag, ".bubble"}, 32'(validW), 0);
         chk({tag, ".req"}, 32'(dmem_req), 1);
         chk({tag, ".addr"}, dmem_addr, t.eAddr);
         chk({tag, ".be"}, 32'(dmem_be), 32'(t.eBe));
         chk({tag, ".wdata"}, dmem_wdata, t.eWd);
         chk({tag, ".we"}, 32'(dmem_we), 32'(t.eWe));
         // The stage must not depend on upstream holding its inputs once the access started.
         validM = 1'($urandom); ALUResultM = $urandom; WriteDataM = $urandom; WA3M = 4'($urandom);
         MemReadM = 1'($urandom); MemWriteM = 1'($urandom); ByteM = 1'($urandom);
         for (int k = 0; k < TO; k++) begin
            if (k == t.ackDly) begin
               dmem_ack = 1; dmem_rdata = t.rdata;
               #1;
               chk({tag, ".stallAck"}, 32'(StallM), 0);
               tick();
               dmem_ack = 0;
               expAcc++;
               checkW(t, tag);
               chk({tag, ".reqDrop"}, 32'(dmem_req), 0);
               break;
            end else if (k == TO - 1) begin
               dmem_rdata = $urandom;
               #1;
               chk({tag, ".stallTo"}, 32'(StallM), 0);
               tick();
               checkW(t, tag);
               chk({tag, ".reqTo"}, 32'(dmem_req), 0);
            end else begin
               dmem_rdata = $urandom;
               #1;
               chk({tag, ".stallWait"}, 32'(StallM), 1);
               expStl++;
               tick();
               chk({tag, ".bubbleWait"}, 32'(validW), 0);
               chk({tag, ".regWait"}, 32'(RegWriteW), 0);
               chk({tag, ".reqHeld"}, 32'(dmem_req), 1);
               chk({tag, ".addrHeld"}, dmem_addr, t.eAddr);
            end
         end
      end
      driveIdle();
   endtask

   initial begin
      vec_t r;
      // Directed vectors with hand-derived expectations.
      tbl[0] = '{default: 0, v: 1, addr: 32'h1234, wa3: 5, rw: 1, eRw: 1, eVal: 1};
      tbl[1] = '{default: 0, v: 1, addr: 32'h100, wa3: 3, rd: 1, rw: 1, m2r: 1, ackDly: 2,
                 rdata: 32'hCAFE_F00D, bus: 1, eAddr: 32'h100, eBe: 4'hF, eRd: 32'hCAFE_F00D,
                 eRw: 1, eVal: 1};
      tbl[2] = '{default: 0, v: 1, addr: 32'h203, wd: 32'hA5, wr: 1, bt: 1, ackDly: 0, bus: 1,
                 eAddr: 32'h200, eBe: 4'b1000, eWd: 32'hA5A5_A5A5, eWe: 1, eVal: 1};
      tbl[3] = '{default: 0, v: 1, addr: 32'h202, wa3: 7, rd: 1, bt: 1, rw: 1, m2r: 1, ackDly: 0,
                 rdata: 32'h1122_3344, bus: 1, eAddr: 32'h200, eBe: 4'b0100, eRd: 32'h22,
                 eRw: 1, eVal: 1};
      tbl[4] = '{default: 0, v: 1, addr: 32'h102, wa3: 2, rd: 1, rw: 1, m2r: 1, eErr: 1, eVal: 1};
      tbl[5] = '{default: 0, v: 0, addr: 32'h55, wa3: 9, rd: 1, m2r: 1};
      tbl[6] = '{default: 0, v: 1, addr: 32'h400, wd: 32'h1234_5678, rd: 1, wr: 1, ackDly: 1,
                 rdata: 32'hFFFF_FFFF, bus: 1, eAddr: 32'h400, eBe: 4'hF, eWd: 32'h1234_5678,
                 eWe: 1, eVal: 1};
      tbl[7] = '{default: 0, v: 1, addr: 32'h300, wd: 32'hDEAD_BEEF, wa3: 4, wr: 1, rw: 1,
                 ackDly: 99, bus: 1, eAddr: 32'h300, eBe: 4'hF, eWd: 32'hDEAD_BEEF, eWe: 1,
                 eErr: 1, eVal: 1};

      // Reset with live non-memory inputs: everything registered must read zero.
      driveIdle();
      reset_n = 0;
      validM = 1; ALUResultM = 32'h9999; WA3M = 6; RegWriteM = 1;
      tick();
      tick();
      chk("rst.validW", 32'(validW), 0);
      chk("rst.ALUOutW", ALUOutW, 0);
      chk("rst.RegWriteW", 32'(RegWriteW), 0);
      chk("rst.req", 32'(dmem_req), 0);
      chk("rst.ErrorW", 32'(ErrorW), 0);
      driveIdle();
      reset_n = 1;
      expAcc = 0; expStl = 0;

      for (int i = 0; i < 8; i++)
         runOp(tbl[i], $sformatf("vec%0d", i));

      // Late ack after the timeout must be ignored.
      dmem_ack = 1; dmem_rdata = 32'h7777_7777;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("late.stall", 32'(StallM), 0);
         tick();
         chk("late.req", 32'(dmem_req), 0);
         chk("late.validW", 32'(validW), 0);
         chk("late.ErrorW", 32'(ErrorW), 0);
      end
      driveIdle();
`ifdef MEM_ACCESS_CNT_EN
      chk("cnt.access", accCnt, 32'(expAcc));
      chk("cnt.stall", stlCnt, 32'(expStl));
`endif

      // Reset in the middle of an access.
      r = '{default: 0, v: 1, addr: 32'h500, wa3: 1, rd: 1, rw: 1, m2r: 1};
      drive(r);
      #1;
      tick();
      chk("midrst.req", 32'(dmem_req), 1);
      tick();
      reset_n = 0;
      tick();
      chk("midrst.reqDrop", 32'(dmem_req), 0);
      chk("midrst.be", 32'(dmem_be), 0);
      chk("midrst.addr", dmem_addr, 0);
      chk("midrst.validW", 32'(validW), 0);
      chk("midrst.WA3W", 32'(WA3W), 0);
      chk("midrst.MemtoRegW", 32'(MemtoRegW), 0);
      reset_n = 1;
      driveIdle();
      expAcc = 0; expStl = 0;
`ifdef MEM_ACCESS_CNT_EN
      chk("midrst.cntAcc", accCnt, 0);
      chk("midrst.cntStl", stlCnt, 0);
`endif
      dmem_ack = 1; dmem_rdata = 32'h1;
      #1;
      chk("midrst.stall", 32'(StallM), 0);
      tick();
      chk("midrst.ackIgnored", 32'(dmem_req), 0);
      chk("midrst.validW2", 32'(validW), 0);
      chk("midrst.ReadDataW", ReadDataW, 0);
      driveIdle();

      // Random instructions against the transaction model.
      for (int i = 0; i < 60; i++) begin
         r = '{default: 0};
         r.v = ($urandom_range(0, 9) != 0);
         r.addr = $urandom;
         r.wd = $urandom;
         r.wa3 = 4'($urandom);
         r.rd = 1'($urandom);
         r.wr = 1'($urandom);
         r.bt = 1'($urandom);
         r.rw = 1'($urandom);
         r.m2r = 1'($urandom);
         r.ackDly = $urandom_range(0, TO + 1);
         r.rdata = $urandom;
         runOp(mkExp(r), $sformatf("rnd%0d", i));
      end
`ifdef MEM_ACCESS_CNT_EN
      chk("rnd.cntAcc", accCnt, 32'(expAcc));
      chk("rnd.cntStl", stlCnt, 32'(expStl));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_mem_access.md
Name: pipe_mem_access

Overview:
Memory stage between the EX/MEM pipeline register and writeback. Takes the ALU result, store data and destination register from EX/MEM, runs a req/ack data-memory transaction that can wait an arbitrary number of cycles (the camera frame buffer shares the bus), and stalls upstream while it waits. Registers the MEM/WB outputs: read data, ALU result, WA3 and control.

Parameters:
TIMEOUT_CYCLES, 64, ACCESS cycles without dmem_ack before the access is aborted with an error (legal range 2..255).
ALIGN_CHECK, 1, if 1, a word access with addr[1:0]!=0 faults and issues no bus request. If 0, addr[1:0] is ignored for word accesses.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous reset, active-low
validM  in  1  instruction in MEM is valid
ALUResultM  in  32  address or ALU result
WriteDataM  in  32  store data
WA3M  in  4  destination register
MemReadM / MemWriteM / ByteM  in  1 each  load, store, byte access
RegWriteM / MemtoRegM  in  1 each  writeback control
StallM  out  1  hold EX/MEM and earlier stages
dmem_req / dmem_we  out  1 each  bus request, write enable
dmem_addr  out  32  bus address, word aligned
dmem_wdata  out  32  bus write data
dmem_be  out  4  byte enables
dmem_ack  in  1  transaction complete
dmem_rdata  in  32  read data, valid with dmem_ack
ReadDataW / ALUOutW  out  32 each  to writeback
WA3W  out  4  to writeback
validW / RegWriteW / MemtoRegW / ErrorW  out  1 each  to writeback

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE, timeout counter 0. All registered outputs go to 0, including dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be and all *W outputs. This applies mid-transaction too: dmem_req drops and any ack that arrives later is ignored.
- memop = validM & (MemReadM | MemWriteM). MemReadM and MemWriteM both high is treated as a store.
- FSM has two states: IDLE and ACCESS.
- IDLE, no memop: *W outputs load from the *M inputs at the next edge (latency 1). ReadDataW=0, ErrorW=0, StallM=0.
- IDLE, memop, misaligned (word access, addr[1:0]!=0, ALIGN_CHECK=1): no bus request. *W loaded with validW=1, RegWriteW=0, ErrorW=1 (latency 1). StallM=0.
- IDLE, memop, aligned: StallM=1 combinationally. At the edge the block latches address, data and control, enters ACCESS, and writes a bubble to W (validW=0, RegWriteW=0).
- ACCESS outputs, driven from registers and held stable until ack:
  - dmem_req=1.
  - dmem_addr={addr[31:2],2'b00}.
  - dmem_we=store.
  - Word access: dmem_be=4'b1111, dmem_wdata=WriteData.
  - Byte access: dmem_be=4'b0001<<addr[1:0], dmem_wdata=4 copies of WriteData[7:0].
- ACCESS, dmem_ack=0: StallM=1, bubble to W, counter increments.
- ACCESS, dmem_ack=1: StallM=0 in that same cycle. At the edge:
  - W loads the latched instruction with ErrorW=0.
  - ReadDataW = dmem_rdata for a word load; the zero-extended byte dmem_rdata[8*addr[1:0]+:8] for a byte load; 0 for a store.
  - State returns to IDLE and dmem_req=0 in the next cycle.
  - Minimum latency for a memory op is 2 edges.
- ACCESS, counter reaches TIMEOUT_CYCLES-1 with no ack: abort. dmem_req=0, W gets validW=1, RegWriteW=0, ErrorW=1, ReadDataW=0. State goes to IDLE and StallM drops in that cycle.
- dmem_ack is ignored outside ACCESS.
- Upstream holds the *M inputs stable while StallM=1. The block does not rely on this after entering ACCESS.
- There is no back-to-back request without an IDLE cycle between: dmem_req deasserts for at least 1 cycle after each ack.

Optional Feature:
MEM_ACCESS_CNT_EN
- Defined: adds outputs mem_access_cnt[31:0] (increments on each ack) and mem_stall_cnt[31:0] (increments each cycle StallM=1). Both are cleared by reset and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Non-mem op: validM=1, ALUResultM=0x0000_1234, WA3M=5, RegWriteM=1 → next edge ALUOutW=0x1234, WA3W=5, validW=1, RegWriteW=1. No dmem_req, StallM=0.
- Word load from 0x100, ack after 3 ACCESS cycles with rdata=0xCAFE_F00D → dmem_addr=0x100, be=1111. StallM high for 3 cycles with 3 bubbles. Then ReadDataW=0xCAFEF00D, MemtoRegW=1, dmem_req low the following cycle.
- Byte store to 0x203, WriteDataM=0x0000_00A5, immediate ack → be=4'b1000, wdata=0xA5A5A5A5, dmem_we=1. Byte load from 0x202 with rdata=0x11223344 → ReadDataW=0x00000022.
- Word load from 0x102, ALIGN_CHECK=1 → no dmem_req, ErrorW=1, RegWriteW=0 after 1 edge.
- TIMEOUT_CYCLES=4, ack never asserted → dmem_req high 4 cycles then low, ErrorW=1, ReadDataW=0, StallM drops. A late ack afterwards is ignored.
- reset_n=0 for 1 cycle during ACCESS → dmem_req=0 and all W outputs 0 next edge, state IDLE. With MEM_ACCESS_CNT_EN, both counters read 0.
